txrx_link_ctrl: RTL and testbench

Link sequencer between the `Transmiter` and `Receiver` in the async transmission top level. On a rising edge of `Start` it captures `SWIn` and drives one transmit request, then waits for the looped-back frame. It compares the received frame against the sent data and acknowledges the receiver. Failed transfers are retried up to a bounded count, and done/fail status is reported upward.

---
 rtl/txrx_link_ctrl.sv | 158 +++++++++++++++
 tb/tb_txrx_link_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/txrx_link_ctrl.sv
// Link sequencer between the transmitter and receiver. It sends one captured frame,
// checks the looped-back copy, acknowledges the receiver and retries failed transfers.
module txrx_link_ctrl #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  input  logic [9:0] SWIn,
  output logic       TX_START,
  output logic [9:0] TX_DATA,
  input  logic       TX_BUSY,
  input  logic       RX_READY,
  input  logic       RX_ERROR,
  input  logic [9:0] Frame,
  output logic       DATA_ACK,
  output logic       LINK_BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_REQ, S_TX_RUN, S_RX_WAIT, S_ACK, S_ERR, S_DONE
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      state;
  logic        start_q;
  logic [15:0] wait_cnt;
  logic        result_ok;
  logic        start_edge;
  logic        timed_out;

  assign start_edge = Start & ~start_q;
  assign timed_out  = (wait_cnt == WAIT_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      wait_cnt  <= '0;
      result_ok <= 1'b0;
      TX_START  <= 1'b0;
      TX_DATA   <= '0;
      DATA_ACK  <= 1'b0;
      LINK_BUSY <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      RETRY_CNT <= '0;
      ERR_CNT   <= '0;
    end else begin
      start_q  <= Start;
      // NOTE: defaults first; a later non-blocking assignment in the case overrides them.
      DONE     <= 1'b0;
      FAIL     <= 1'b0;
      wait_cnt <= wait_cnt + 16'd1;

      unique case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (start_edge) begin
            state     <= S_TX_REQ;
            TX_DATA   <= SWIn;
            RETRY_CNT <= '0;
            TX_START  <= 1'b1;
            LINK_BUSY <= 1'b1;
          end
        end

        S_TX_REQ: begin
          if (TX_BUSY) begin
            state    <= S_TX_RUN;
            TX_START <= 1'b0;
            wait_cnt <= '0;
          end else if (timed_out) begin
            state    <= S_ERR;
            TX_START <= 1'b0;
            wait_cnt <= '0;
          end
        end

        S_TX_RUN: begin
          if (!TX_BUSY) begin
            state    <= S_RX_WAIT;
            wait_cnt <= '0;
          end else if (timed_out) begin
            state    <= S_ERR;
            wait_cnt <= '0;
          end
        end

        S_RX_WAIT: begin
          if (RX_READY || RX_ERROR) begin
            state     <= S_ACK;
            DATA_ACK  <= 1'b1;
            // A receiver error makes the attempt bad whatever the frame holds.
            result_ok <= !RX_ERROR && (Frame == TX_DATA);
            wait_cnt  <= '0;
          end else if (timed_out) begin
            state    <= S_ERR;
            wait_cnt <= '0;
          end
        end

        S_ACK: begin
          if (!RX_READY && !RX_ERROR) begin
            DATA_ACK <= 1'b0;
            wait_cnt <= '0;
            if (result_ok) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (timed_out) begin
            state    <= S_ERR;
            DATA_ACK <= 1'b0;
            wait_cnt <= '0;
          end
        end

        S_ERR: begin
          wait_cnt <= '0;
          if (RETRY_CNT != RETRY_MAX) begin
            RETRY_CNT <= RETRY_CNT + 4'd1;
            state     <= S_TX_REQ;
            TX_START  <= 1'b1;
          end else begin
            FAIL      <= 1'b1;
            LINK_BUSY <= 1'b0;
            state     <= S_IDLE;
            if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
          end
        end

        S_DONE: begin
          wait_cnt  <= '0;
          LINK_BUSY <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          wait_cnt  <= '0;
          TX_START  <= 1'b0;
          DATA_ACK  <= 1'b0;
          LINK_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_txrx_link_ctrl.sv
// Bench for txrx_link_ctrl: acts as transmitter and receiver, predicts each transfer's
// outcome from its per-attempt results, and checks handshakes, pulses and counters.
module tb_txrx_link_ctrl;

  localparam int MAX_RETRY = 3;
  localparam int ATTEMPTS  = MAX_RETRY + 1;
  localparam int TIMEOUT   = 200;
  localparam int TIMEOUT_T = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] sw_in;
  logic       tx_busy, rx_ready, rx_error;
  logic [9:0] rx_frame;
  logic       tx_start, data_ack, link_busy, done, fail;
  logic [9:0] tx_data;
  logic [3:0] retry_cnt;
  logic [7:0] err_cnt;

  logic       t_start;
  logic       t_tx_start, t_data_ack, t_link_busy, t_done, t_fail;
  logic [9:0] t_tx_data;
  logic [3:0] t_retry_cnt;
  logic [7:0] t_err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_err     = 0;

  always #5 clk = ~clk;

  txrx_link_ctrl #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RSTn(rst_n), .Start(start), .SWIn(sw_in),
    .TX_START(tx_start), .TX_DATA(tx_data), .TX_BUSY(tx_busy),
    .RX_READY(rx_ready), .RX_ERROR(rx_error), .Frame(rx_frame),
    .DATA_ACK(data_ack), .LINK_BUSY(link_busy), .DONE(done), .FAIL(fail),
    .RETRY_CNT(retry_cnt), .ERR_CNT(err_cnt)
  );

  // Second instance with a short timeout and no retries; its transmitter never answers.
  txrx_link_ctrl #(.MAX_RETRY(0), .TIMEOUT(TIMEOUT_T)) dut_t (
    .CLK(clk), .RSTn(rst_n), .Start(t_start), .SWIn(10'h155),
    .TX_START(t_tx_start), .TX_DATA(t_tx_data), .TX_BUSY(1'b0),
    .RX_READY(1'b0), .RX_ERROR(1'b0), .Frame(10'h000),
    .DATA_ACK(t_data_ack), .LINK_BUSY(t_link_busy), .DONE(t_done), .FAIL(t_fail),
    .RETRY_CNT(t_retry_cnt), .ERR_CNT(t_err_cnt)
  );

  int   tx_rises = 0, done_cycles = 0, fail_cycles = 0;
  int   t_tx_cycles = 0, t_fail_cycles = 0, t_done_cycles = 0;
  logic tx_start_prev = 1'b0;

  always @(negedge clk) begin
    if (tx_start && !tx_start_prev) tx_rises++;
    tx_start_prev = tx_start;
    if (done) done_cycles++;
    if (fail) fail_cycles++;
    if (t_tx_start) t_tx_cycles++;
    if (t_fail) t_fail_cycles++;
    if (t_done) t_done_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (tx_start === 1'b1);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (link_busy === 1'b0);
    end
  endtask

  // kind: 0 matching frame, 1 corrupted frame, 2 receiver error, 3 ready+error with matching frame
  task automatic do_attempt(input logic [9:0] data, input logic [1:0] kind,
                            input int busy_len, input bit toggle);
    bit         ok;
    logic [9:0] frm;
    wait_tx_start(ok);
    check("tx_start_seen", 32'(ok), 32'd1);
    check("tx_data", 32'(tx_data), 32'(data));
    tx_busy = 1'b1;
    @(negedge clk);
    check("tx_start_drop", 32'(tx_start), 32'd0);
    for (int i = 1; i < busy_len; i++) begin
      @(negedge clk);
      if (toggle && i == 1) start = 1'b1;
      if (toggle && i == 2) start = 1'b0;
    end
    tx_busy = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    check("data_ack_idle", 32'(data_ack), 32'd0);
    frm = data;
    if (kind == 2'd1) frm = data ^ (10'd1 << $urandom_range(0, 9));
    rx_frame = frm;
    rx_ready = (kind != 2'd2);
    rx_error = (kind >= 2'd2);
    @(negedge clk);
    check("data_ack_set", 32'(data_ack), 32'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("data_ack_hold", 32'(data_ack), 32'd1);
    rx_ready = 1'b0;
    rx_error = 1'b0;
    rx_frame = 10'($urandom);
    @(negedge clk);
    check("data_ack_release", 32'(data_ack), 32'd0);
    check("done_at_release", 32'(done), 32'(kind == 2'd0));
  endtask

  task automatic transfer(input logic [9:0] data, input logic [2*ATTEMPTS-1:0] kinds,
                          input int busy_len, input bit toggle);
    int exp_att;
    bit exp_ok;
    bit ok;
    int tx0, d0, f0;
    // Outcome: the first good attempt within the allowed count succeeds; otherwise fail.
    exp_att = ATTEMPTS;
    exp_ok  = 1'b0;
    for (int a = 0; a < ATTEMPTS; a++)
      if (!exp_ok && kinds[2*a +: 2] == 2'd0) begin
        exp_ok  = 1'b1;
        exp_att = a + 1;
      end
    if (!exp_ok && exp_err < 255) exp_err++;

    @(negedge clk);
    tx0 = tx_rises; d0 = done_cycles; f0 = fail_cycles;
    sw_in = data;
    start = 1'b1;
    @(negedge clk);
    check("start_link_busy", 32'(link_busy), 32'd1);
    check("start_tx_start", 32'(tx_start), 32'd1);
    sw_in = 10'($urandom);
    start = 1'b0;
    for (int a = 0; a < exp_att; a++)
      do_attempt(data, kinds[2*a +: 2], busy_len, toggle && a == 0);
    if (exp_ok) begin
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("idle_after_done", 32'(link_busy), 32'd0);
    end
    wait_idle(ok);
    check("return_idle", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check("tx_start_count", 32'(tx_rises - tx0), 32'(exp_att));
    check("done_cycles", 32'(done_cycles - d0), 32'(exp_ok));
    check("fail_cycles", 32'(fail_cycles - f0), 32'(!exp_ok));
    check("retry_cnt", 32'(retry_cnt), 32'(exp_att - 1));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    check("stays_idle", 32'(link_busy), 32'd0);
  endtask

  initial begin
    int  d0, f0, t0, tf0;
    bit  ok;
    rst_n = 1'b0; start = 1'b0; t_start = 1'b0; sw_in = '0;
    tx_busy = 1'b0; rx_ready = 1'b0; rx_error = 1'b0; rx_frame = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_data_ack", 32'(data_ack), 32'd0);
    check("rst_link_busy", 32'(link_busy), 32'd0);
    check("rst_done_fail", 32'({done, fail}), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);

    // Timeout: transmitter never goes busy; request is held for exactly TIMEOUT_T cycles.
    t0 = t_tx_cycles; tf0 = t_fail_cycles;
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (TIMEOUT_T + 10) @(negedge clk);
    check("to_tx_cycles", 32'(t_tx_cycles - t0), 32'(TIMEOUT_T));
    check("to_fail", 32'(t_fail_cycles - tf0), 32'd1);
    check("to_done", 32'(t_done_cycles), 32'd0);
    check("to_idle", 32'(t_link_busy), 32'd0);
    check("to_err_cnt", 32'(t_err_cnt), 32'd1);
    check("to_retry", 32'(t_retry_cnt), 32'd0);
    check("to_data_ack", 32'(t_data_ack), 32'd0);
    check("to_tx_data", 32'(t_tx_data), 32'h155);

    transfer(10'h2A5, 8'h00, 80, 1'b0);   // clean loopback
    transfer(10'h2A5, 8'h01, 5, 1'b0);    // mismatch then success
    transfer(10'h2A5, 8'hAA, 4, 1'b0);    // receiver error every attempt
    transfer(10'h0F3, 8'h03, 4, 1'b0);    // ready+error together counts as bad
    transfer(10'h1C6, 8'h00, 6, 1'b1);    // Start toggled while transmitting

    for (int n = 0; n < 20; n++)
      transfer(10'($urandom), 8'($urandom), int'($urandom_range(3, 12)), 1'($urandom));

    // Mid-transfer reset while waiting for the receiver.
    @(negedge clk);
    sw_in = 10'h3C3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tx_start(ok);
    check("mid_tx_start", 32'(ok), 32'd1);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cycles; f0 = fail_cycles;
    check("mid_in_transfer", 32'(link_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    check("mid_rst_outs", 32'({tx_start, data_ack, link_busy, done, fail}), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_cnts", 32'({retry_cnt, err_cnt}), 32'd0);
    repeat (4) @(negedge clk);
    check("mid_rst_idle", 32'(link_busy), 32'd0);
    check("mid_rst_no_pulse", 32'((done_cycles - d0) + (fail_cycles - f0)), 32'd0);
    transfer(10'h3C3, 8'h00, 4, 1'b0);

    // Saturation of the failed-transfer counter.
    for (int n = 0; n < 256; n++)
      transfer(10'($urandom), 8'hAA, 3, 1'b0);
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached (vectors %0d)", vectors);
    $fatal(1);
  end

endmodule
